sw_logic_gate: RTL
==================

SW_LOGIC_GATE -- requirements
Module: sw_logic_gate

Interface
REQ-001 Parameter WIDTH, default 2: number of switch inputs combined; legal range 2..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive differing samples required before a debounced input changes; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port sw, input, WIDTH: asynchronous switch inputs, for example board SW0..SWn.
REQ-006 Port op, input, 3: synchronous operation select.
REQ-007 Port out, output, 1: registered logic result, for example driving LD0.
REQ-008 Port changed, output, 1: one-cycle pulse when out toggles.
REQ-009 Port op_err, output, 1: registered flag indicating a reserved op code.

Function
REQ-010 Each sw bit SHALL pass through a 2-flop synchroniser (s1, then s2) before any other use.
REQ-011 Each bit SHALL have its own debounce counter, sized ceil(log2(DEBOUNCE_CYCLES+1)) bits, and its own stable bit.
REQ-012 Each clock, for each bit, the debounce logic SHALL apply these rules:
- If s2 equals stable: cnt is set to 0.
- Else if cnt equals DEBOUNCE_CYCLES-1: stable is set to s2 and cnt is set to 0.
- Else: cnt is incremented by 1.
REQ-013 Any excursion on s2 shorter than DEBOUNCE_CYCLES cycles SHALL leave stable unchanged and reset cnt to 0 when s2 returns to stable.
REQ-014 Each clock, out SHALL be registered from the debounced vector d = stable[WIDTH-1:0] using op:
- 0 = AND of all bits
- 1 = OR
- 2 = XOR (odd parity)
- 3 = NAND
- 4 = NOR
- 5 = XNOR
- 6 = pass d[0]
- 7 = reserved
REQ-015 For op = 7, out SHALL load 0 and op_err SHALL load 1; for op = 0..6, op_err SHALL load 0.
REQ-016 op SHALL NOT be synchronised or debounced; an op change SHALL appear on out and op_err one cycle later.
REQ-017 Latency from an sw change, held steady, to the new out SHALL be 3+DEBOUNCE_CYCLES cycles (7 at default).
REQ-018 changed SHALL be 1 for exactly the cycle after the out register changes value; this SHALL include toggles caused by op changes.
REQ-019 Simultaneous changes on several sw bits SHALL be debounced independently; out SHALL reflect each stable update as it occurs.
REQ-020 Counters SHALL never wrap: the maximum value reached is DEBOUNCE_CYCLES-1.

Reset
REQ-021 While rst = 1, the following SHALL be cleared on the next clock edge:
- s1, s2, stable, cnt: 0
- out: 0
- changed: 0
- op_err: 0
REQ-022 Asserting rst mid-debounce SHALL discard partial counts; after release, debouncing SHALL restart from stable = 0.
REQ-023 changed SHALL NOT pulse on the first cycle after reset release due to reset itself.
REQ-024 The first out update after reset SHALL occur on the first clock with rst = 0.

Verification
REQ-025 WIDTH=2, DC=4, op=0: sw=2'b11 held from cycle 0 -> out=1 at cycle 7; changed=1 at cycle 8 only.
REQ-026 op=0, debounced d=2'b11: sw[1] glitches to 0 for 3 cycles -> out stays 1; changed never asserts.
REQ-027 d=2'b10: step op through 0..6 one per cycle -> out sequence 0,1,1,1,0,0,0, each one cycle after its op; op=7 -> out=0, op_err=1.
REQ-028 op=0, d=2'b11, out=1: assert rst for 1 cycle -> out=0 next cycle; after release with sw still 11, out returns to 1 exactly 7 cycles after the first non-reset cycle.
REQ-029 WIDTH=4, DC=1, op=2: sw=4'b0111 -> out=1 after 4 cycles; then sw=4'b1111 -> out=0 after 4 cycles, with a changed pulse each time.

Source files
------------

// File: rtl/sw_logic_gate.sv
// -----------------------------------------------------------------------------
// sw_logic_gate
//
// Purpose:
//   Combines WIDTH asynchronous board switches into one registered logic
//   result. Each switch is synchronised with two flops, then debounced by its
//   own counter. The debounced vector is reduced by the operation selected on
//   op, and the result is registered onto out.
//
// Parameters:
//   WIDTH            number of switch inputs (2..16)
//   DEBOUNCE_CYCLES  consecutive differing samples needed to accept a new
//                    switch level (1..255)
//
// Ports:
//   clk      in   single clock, all state updates on its rising edge
//   rst      in   synchronous active-high reset
//   sw       in   [WIDTH-1:0] asynchronous switch inputs
//   op       in   [2:0] operation select (0 AND, 1 OR, 2 XOR, 3 NAND,
//                 4 NOR, 5 XNOR, 6 pass d[0], 7 reserved)
//   out      out  registered logic result
//   changed  out  one-cycle pulse in the cycle after out changes value
//   op_err   out  registered flag, set while op selects the reserved code
// -----------------------------------------------------------------------------
module sw_logic_gate #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [2:0]       op,
    output logic             out,
    output logic             changed,
    output logic             op_err
);

    // Counter is wide enough to hold DEBOUNCE_CYCLES; it only ever reaches
    // DEBOUNCE_CYCLES-1 because the last differing sample commits instead.
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic             out_prev;
    logic             out_next;
    logic             err_next;

    // Reduce the debounced vector according to the selected operation.
    // The reserved code forces a 0 result.
    function automatic logic apply_op(input logic [2:0] sel,
                                      input logic [WIDTH-1:0] d);
        logic r;
        case (sel)
            OP_AND:  r = &d;
            OP_OR:   r = |d;
            OP_XOR:  r = ^d;
            OP_NAND: r = ~&d;
            OP_NOR:  r = ~|d;
            OP_XNOR: r = ~^d;
            OP_PASS: r = d[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Two-flop synchroniser: s1 may go metastable, s2 is the first flop any
    // downstream logic is allowed to look at.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // Independent debounce per bit. A sample that agrees with the accepted
    // level clears the count, so any excursion shorter than DEBOUNCE_CYCLES
    // samples is forgotten entirely.
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             stb;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                stb <= 1'b0;
            end else if (s2[i] == stb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stb <= s2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[i] = stb;
    end

    always_comb begin
        out_next = apply_op(op, stable);
        err_next = (op == OP_RSVD);
    end

    // Output register. changed compares out against its previous value, so
    // it rises in the cycle after out moves. Reset clears both out and
    // out_prev together, so leaving reset never produces a spurious pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= 1'b0;
            out_prev <= 1'b0;
            changed  <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            out      <= out_next;
            op_err   <= err_next;
            out_prev <= out;
            changed  <= out ^ out_prev;
        end
    end

endmodule
